load_use_scoreboard: RTL and testbench
======================================

Name: load_use_scoreboard

Overview:
- Parametrised successor to the combinational load-use hazard check in the 16-bit pipeline's decode stage.
- Keeps a per-register scoreboard of in-flight load destinations with a configurable load latency.
- Stalls decode while any source register of the decoding instruction is still pending.
- Exposes an issue strobe, the busy mask and a saturating stall-cycle counter for performance monitoring.

Parameters:
- INSTR_W, 16, instruction width; field positions come from the shared package.
- RADDR_W, 3, register address width.
- NUM_REGS, 8, scoreboard entries; must equal 2**RADDR_W.
- LOAD_LAT, 1, stall cycles owed by a consumer issued directly behind a load; range 1..7.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_instr  input  INSTR_W  instruction currently held in decode.
- id_valid  input  1  id_instr is a real instruction.
- flush  input  1  kill the decode instruction this cycle (branch redirect).
- stall  output  1  hold fetch/decode; combinational from the registered scoreboard and id_instr.
- issue  output  1  decode instruction advances to EX this cycle.
- busy_mask  output  NUM_REGS  registered; bit r set while register r has a pending load.
- stall_count  output  CNT_W  registered; saturating count of stall cycles.

Behaviour:
- Field decode (package function): op1=[15:14], ra=[13:11], rb=[10:8], op3=[7:4].
- Load: op1==00 and instr != 0; destination is ra. The all-zero instruction is a NOP and never loads.
- Source use, op1==00 or 01: rb only.
- Source use, op1==11: op3 0000..0101 read ra and rb; 0110 reads ra; 1000..1011 read rb; any other op3 reads nothing.
- Source use, op1==10: reads nothing.
- Scoreboard: one counter per register, width clog2(LOAD_LAT+1); busy_mask[r] = (cnt[r] != 0).
- stall = id_valid & !flush & (any used source r with cnt[r] != 0).
- issue = id_valid & !flush & !stall.
- Each clock: every nonzero counter decrements by 1.
- When issue and id_instr is a load, cnt[ra] <= LOAD_LAT. The reload overrides the decrement for that entry, including re-loading an already pending register.
- Timing: a load issued in cycle t makes a dependent instruction decoding in t+1 stall for exactly LOAD_LAT cycles; it issues in cycle t+1+LOAD_LAT. With LOAD_LAT=1 this matches the previous generation's one-bubble behaviour.
- Flush: suppresses issue and stall for that cycle. Counters keep decrementing, because older loads still complete.
- stall_count: +1 on every cycle with stall=1; holds at all-ones, no wrap.
- Reset (async assert, any time including mid-stall): all counters 0, busy_mask 0, stall_count 0. stall and issue therefore drop immediately. Reset deassertion is synchronised externally.
- No X-propagation: when id_valid=0, stall=0 and issue=0 regardless of id_instr.

Decomposition:
- Package load_use_pkg holds:
  - field LSB/MSB localparams;
  - op1 encodings OP_LOAD, OP_STORE, OP_BR, OP_ALU;
  - functions is_load(), uses_ra(), uses_rb(), which are the single source of truth for decode.
- Sub-module scoreboard_entry: one down-counter with load/decrement and a busy flag, instantiated NUM_REGS times via generate.
- The top level holds the stall/issue logic and the performance counter.

Test Plan:
- LOAD_LAT=1: issue 16'h1A00 (load r3), then decode 16'hC300 (ALU op3=0000, rb=r3). Expect stall=1 for exactly 1 cycle, issue in the next cycle, stall_count=1, busy_mask=8'h08 during the stall.
- LOAD_LAT=3: same sequence. Expect 3 consecutive stall cycles, stall_count=3, busy_mask cleared on the cycle issue rises.
- Load r3, then 16'hCB60 (op3=0110, ra=r1, rb=r3 unused). Expect no stall; 16'h0000 NOP issued repeatedly leaves busy_mask=0.
- LOAD_LAT=3: load r3, then immediately load r3 again (16'h1A00 twice, second issued while pending). Expect cnt[r3] reloaded to 3, and the consumer stalls 3 cycles after the second load.
- Flush asserted in the second stall cycle with LOAD_LAT=3. Expect stall=0 and issue=0 that cycle, busy_mask still 8'h08, and the counter reaching 0 on schedule.
- Assert rst_n=0 mid-stall. Expect stall, busy_mask and stall_count at 0 before the next clk edge. Force stall high for 2**CNT_W+5 cycles and expect stall_count to hold at 16'hFFFF.

Source files
------------

// File: rtl/load_use_scoreboard_pkg.sv
// Shared decode definitions for the load-use scoreboard: instruction field
// positions, op1 encodings and the decode helpers every consumer must use.
package load_use_pkg;

    localparam int INSTR_W_PKG = 16;

    localparam int OP1_MSB = 15;
    localparam int OP1_LSB = 14;
    localparam int RA_MSB  = 13;
    localparam int RA_LSB  = 11;
    localparam int RB_MSB  = 10;
    localparam int RB_LSB  = 8;
    localparam int OP3_MSB = 7;
    localparam int OP3_LSB = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_BR    = 2'b10,
        OP_ALU   = 2'b11
    } op1_e;

    typedef logic [INSTR_W_PKG-1:0] instr_t;

    function automatic op1_e op1_of(input instr_t instr);
        return op1_e'(instr[OP1_MSB:OP1_LSB]);
    endfunction

    function automatic logic [3:0] op3_of(input instr_t instr);
        return instr[OP3_MSB:OP3_LSB];
    endfunction

    // The all-zero word is the NOP, so it must never claim a destination.
    function automatic logic is_load(input instr_t instr);
        return (op1_of(instr) == OP_LOAD) && (instr != '0);
    endfunction

    function automatic logic uses_ra(input instr_t instr);
        return (op1_of(instr) == OP_ALU) && (op3_of(instr) <= 4'b0110);
    endfunction

    function automatic logic uses_rb(input instr_t instr);
        logic [3:0] op3;
        logic       result;
        op3    = op3_of(instr);
        result = 1'b0;
        case (op1_of(instr))
            OP_LOAD, OP_STORE: result = 1'b1;
            OP_ALU:            result = (op3 <= 4'b0101) ||
                                        ((op3 >= 4'b1000) && (op3 <= 4'b1011));
            default:           result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_use_scoreboard_if.sv
// Decode-stage handshake between the pipeline front end (master) and the
// load-use scoreboard (slave).
interface load_use_scoreboard_if #(
    parameter int INSTR_W  = 16,
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 16
);

    logic [INSTR_W-1:0]  id_instr;
    logic                id_valid;
    logic                flush;
    logic                stall;
    logic                issue;
    logic [NUM_REGS-1:0] busy_mask;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output id_instr, id_valid, flush,
        input  stall, issue, busy_mask, stall_count
    );

    modport slave (
        input  id_instr, id_valid, flush,
        output stall, issue, busy_mask, stall_count
    );

endinterface

// File: rtl/load_use_scoreboard_entry.sv
// One scoreboard slot: a down-counter armed with the load latency when a load
// targeting this register issues; busy while the counter is nonzero.
module scoreboard_entry #(
    parameter int LOAD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_busy
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    logic [CW-1:0] r_cnt;

    // NOTE: state registers use non-blocking assignments so every entry samples
    // the same pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(LOAD_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/load_use_scoreboard.sv
// Decode-stage load-use interlock: per-register pending-load scoreboard,
// stall/issue generation and a saturating stall-cycle counter.
module load_use_scoreboard
    import load_use_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int RADDR_W  = 3,
    parameter int NUM_REGS = 8,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    load_use_scoreboard_if.slave bus
);

    instr_t              w_instr;
    logic [RADDR_W-1:0]  w_ra;
    logic [RADDR_W-1:0]  w_rb;
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_load;
    logic                w_live;
    logic                w_hazard;
    logic                w_stall;
    logic                w_issue;
    logic [CNT_W-1:0]    r_stall_count;

    assign w_instr = bus.id_instr[INSTR_W_PKG-1:0];
    assign w_ra    = w_instr[RA_MSB:RA_LSB];
    assign w_rb    = w_instr[RB_MSB:RB_LSB];

    // Reset gates the handshake so stall and issue fall with rst_n, not at a clock.
    assign w_live  = rst_n & bus.id_valid & ~bus.flush;
    assign w_stall = w_live & w_hazard;
    assign w_issue = w_live & ~w_hazard;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        w_hazard = 1'b0;
        w_load   = '0;
        if (uses_ra(w_instr) && w_busy[w_ra]) begin
            w_hazard = 1'b1;
        end
        if (uses_rb(w_instr) && w_busy[w_rb]) begin
            w_hazard = 1'b1;
        end
        if (w_issue && is_load(w_instr)) begin
            w_load[w_ra] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        scoreboard_entry #(
            .LOAD_LAT (LOAD_LAT)
        ) u_entry (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (w_load[g]),
            .o_busy (w_busy[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign bus.stall       = w_stall;
    assign bus.issue       = w_issue;
    assign bus.busy_mask   = w_busy;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard: three instances with load latencies
// 1, 3 and 7 share clock and reset, each driven with hand-checked sequences.
module tb_load_use_scoreboard;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    load_use_scoreboard_if #(.INSTR_W(16), .NUM_REGS(8), .CNT_W(16)) b1 ();
    load_use_scoreboard_if #(.INSTR_W(16), .NUM_REGS(8), .CNT_W(16)) b3 ();
    load_use_scoreboard_if #(.INSTR_W(16), .NUM_REGS(8), .CNT_W(16)) b7 ();

    load_use_scoreboard #(.LOAD_LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    load_use_scoreboard #(.LOAD_LAT(3)) u_lat3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    load_use_scoreboard #(.LOAD_LAT(7)) u_lat7 (.clk(clk), .rst_n(rst_n), .bus(b7));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic [15:0] instr, input logic valid,
                         input logic fl);
        case (which)
            1: begin b1.id_instr = instr; b1.id_valid = valid; b1.flush = fl; end
            3: begin b3.id_instr = instr; b3.id_valid = valid; b3.flush = fl; end
            default: begin b7.id_instr = instr; b7.id_valid = valid; b7.flush = fl; end
        endcase
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 16'hC300, 1'b0, 1'b0);
        drive(3, 16'hC300, 1'b0, 1'b0);
        drive(7, 16'hC300, 1'b0, 1'b0);
        repeat (2) tick;
        check("rst_busy",  32'(b3.busy_mask),   'h00);
        check("rst_count", 32'(b3.stall_count), 0);
        check("rst_stall", 32'(b3.stall),       0);
        check("rst_issue", 32'(b3.issue),       0);
        rst_n = 1'b1;
        tick;

        // LOAD_LAT=1: load r3 then ALU consumer of r3 -> one bubble
        drive(1, 16'h1A00, 1'b1, 1'b0);
        check("t1_load_issue", 32'(b1.issue), 1);
        check("t1_load_stall", 32'(b1.stall), 0);
        tick;
        drive(1, 16'hC300, 1'b1, 1'b0);
        check("t1_stall",   32'(b1.stall),     1);
        check("t1_issue_n", 32'(b1.issue),     0);
        check("t1_busy",    32'(b1.busy_mask), 'h08);
        tick;
        check("t1_issue",    32'(b1.issue),       1);
        check("t1_stall_n",  32'(b1.stall),       0);
        check("t1_count",    32'(b1.stall_count), 1);
        check("t1_busy_clr", 32'(b1.busy_mask),   'h00);
        tick;

        // LOAD_LAT=1: op3=0110 reads only ra, so pending rb must not stall
        drive(1, 16'h1A00, 1'b1, 1'b0);
        tick;
        drive(1, 16'hCB60, 1'b1, 1'b0);
        check("t3_nodep_stall", 32'(b1.stall),     0);
        check("t3_nodep_issue", 32'(b1.issue),     1);
        check("t3_nodep_busy",  32'(b1.busy_mask), 'h08);
        tick;
        // A pending producer plus an invalid consumer word must stay quiet
        drive(1, 16'h1A00, 1'b1, 1'b0);
        tick;
        drive(1, 16'hC300, 1'b0, 1'b0);
        check("t3_invalid_stall", 32'(b1.stall), 0);
        check("t3_invalid_issue", 32'(b1.issue), 0);
        tick;
        drive(1, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_nop_issue%0d", i), 32'(b1.issue),     1);
            check($sformatf("t3_nop_busy%0d", i),  32'(b1.busy_mask), 'h00);
            tick;
        end
        drive(1, 16'h0000, 1'b0, 1'b0);

        // LOAD_LAT=3: three stall cycles, busy clears as issue rises
        drive(3, 16'h1A00, 1'b1, 1'b0);
        check("t2_load_issue", 32'(b3.issue), 1);
        tick;
        drive(3, 16'hC300, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_stall%0d", i), 32'(b3.stall),     1);
            check($sformatf("t2_busy%0d", i),  32'(b3.busy_mask), 'h08);
            tick;
        end
        check("t2_issue",    32'(b3.issue),       1);
        check("t2_busy_clr", 32'(b3.busy_mask),   'h00);
        check("t2_count",    32'(b3.stall_count), 3);
        tick;
        drive(3, 16'h0000, 1'b0, 1'b0);

        // LOAD_LAT=3: back-to-back loads of r3 rearm the counter
        drive(3, 16'h1A00, 1'b1, 1'b0);
        tick;
        check("t4_reload_issue", 32'(b3.issue),     1);
        check("t4_reload_busy",  32'(b3.busy_mask), 'h08);
        tick;
        drive(3, 16'hC300, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_stall%0d", i), 32'(b3.stall), 1);
            tick;
        end
        check("t4_issue", 32'(b3.issue),       1);
        check("t4_count", 32'(b3.stall_count), 6);
        tick;
        drive(3, 16'h0000, 1'b0, 1'b0);

        // LOAD_LAT=3: flush in the second stall cycle
        drive(3, 16'h1A00, 1'b1, 1'b0);
        tick;
        drive(3, 16'hC300, 1'b1, 1'b0);
        check("t5_stall_a", 32'(b3.stall), 1);
        tick;
        drive(3, 16'hC300, 1'b1, 1'b1);
        check("t5_flush_stall", 32'(b3.stall),     0);
        check("t5_flush_issue", 32'(b3.issue),     0);
        check("t5_flush_busy",  32'(b3.busy_mask), 'h08);
        tick;
        drive(3, 16'hC300, 1'b1, 1'b0);
        check("t5_stall_b", 32'(b3.stall), 1);
        tick;
        check("t5_issue",    32'(b3.issue),       1);
        check("t5_busy_clr", 32'(b3.busy_mask),   'h00);
        check("t5_count",    32'(b3.stall_count), 8);
        tick;
        drive(3, 16'h0000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a stall
        drive(3, 16'h1A00, 1'b1, 1'b0);
        tick;
        drive(3, 16'hC300, 1'b1, 1'b0);
        check("t6_pre_stall", 32'(b3.stall),       1);
        check("t6_pre_count", 32'(b3.stall_count), 8);
        rst_n = 1'b0;
        #1;
        check("t6_rst_stall", 32'(b3.stall),       0);
        check("t6_rst_issue", 32'(b3.issue),       0);
        check("t6_rst_busy",  32'(b3.busy_mask),   'h00);
        check("t6_rst_count", 32'(b3.stall_count), 0);
        #1;
        rst_n = 1'b1;
        drive(3, 16'h0000, 1'b0, 1'b0);
        tick;

        // LOAD_LAT=7: self-dependent load r3<-[r3] stalls 7 of every 8 cycles
        drive(7, 16'h1B00, 1'b1, 1'b0);
        check("t7_first_issue", 32'(b7.issue), 1);
        repeat (800) tick;
        check("t7_count_800", 32'(b7.stall_count), 700);
        check("t7_issue_800", 32'(b7.issue),       1);
        repeat (75000) tick;
        check("t7_sat", 32'(b7.stall_count), 'hFFFF);
        repeat (3) tick;
        check("t7_sat_stall", 32'(b7.stall),       1);
        check("t7_sat_hold",  32'(b7.stall_count), 'hFFFF);
        drive(7, 16'h0000, 1'b0, 1'b0);

        check("lat1_count_after_rst", 32'(b1.stall_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
